// File: rtl/apb_master_ctrl.sv
// APB master controller: accepts one valid/ready request at a time and runs it
// as a SETUP/ACCESS transfer to one of two slaves, aborting after TIMEOUT waits.
module apb_master_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       req_valid,
  input  logic       req_write,
  input  logic [8:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic       PREADY1,
  input  logic       PREADY2,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       psel1_q, psel1_d;
  logic       psel2_q, psel2_d;
  logic       penable_q, penable_d;
  logic       pwrite_q, pwrite_d;
  logic [7:0] paddr_q, paddr_d;
  logic [7:0] pwdata_q, pwdata_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_err_q, rsp_err_d;
  logic       sel_ready_s;
  logic [7:0] sel_rdata_s;

  assign req_ready = (state_q == IDLE) && PRESETn;

  // Route the ready/data of the currently selected slave only.
  always_comb begin
    sel_ready_s = 1'b0;
    sel_rdata_s = 8'h00;
    if (sel_q) begin
      sel_ready_s = PREADY2;
      sel_rdata_s = PRDATA2;
    end else begin
      sel_ready_s = PREADY1;
      sel_rdata_s = PRDATA1;
    end
  end

  // Next-state and next-output logic of the transfer FSM.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 8'h00;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d  = SETUP;
          sel_d    = req_addr[8];
          psel1_d  = ~req_addr[8];
          psel2_d  = req_addr[8];
          pwrite_d = req_write;
          paddr_d  = req_addr[7:0];
          pwdata_d = req_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = 8'h00;
      end
      ACCESS: begin
        if (sel_ready_s) begin
          state_d     = IDLE;
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? 8'h00 : sel_rdata_s;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Ready wins over timeout when both happen in the same cycle.
          state_d     = IDLE;
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers, all cleared asynchronously by PRESETn.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 8'h00;
      pwdata_q    <= 8'h00;
      wait_cnt_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: tests queue expected responses, a
// negedge monitor pops and compares them whenever rsp_valid pulses.
module tb_apb_master_ctrl;

  logic       PCLK, PRESETn;
  logic       req_valid, req_write;
  logic [8:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic       PREADY1, PREADY2;
  logic [7:0] PRDATA1, PRDATA2;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rsp_cnt  = 0;

  apb_master_ctrl #(.TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY1(PREADY1), .PREADY2(PREADY2), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Response monitor: every completion must match the oldest queued expectation.
  always @(negedge PCLK) begin
    if (PRESETn) begin
      n_checks++;
      if ((PSEL1 & PSEL2) !== 1'b0) begin
        n_fail++;
        $display("FAIL psel_exclusive: PSEL1=%b PSEL2=%b", PSEL1, PSEL2);
      end
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got rdata=%h err=%b, no response expected", rsp_rdata, rsp_err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
            n_fail++;
            $display("FAIL rsp_data: got rdata=%h err=%b exp rdata=%h err=%b",
                     rsp_rdata, rsp_err, e.rdata, e.err);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic start_req(input logic w, input logic [8:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic push_exp(input logic [7:0] rd, input logic er);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 9'h000; req_wdata = 8'h00;
    PREADY1 = 1'b0; PREADY2 = 1'b0; PRDATA1 = 8'h00; PRDATA2 = 8'h00;
    tick();
    tick();
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h exp 0", {req_ready, rsp_valid, rsp_err, rsp_rdata,
               PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA});
    end
    PRESETn = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b exp 1", req_ready);
    end
  endtask

  task automatic test_write_slave1();
    PREADY1 = 1'b1; PRDATA1 = 8'hEE;
    start_req(1'b1, 9'h0A5, 8'h3C);
    push_exp(8'h00, 1'b0);
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C}) begin
      n_fail++;
      $display("FAIL wr_setup: got sel1=%b sel2=%b en=%b wr=%b a=%h d=%h exp 1 0 0 1 a5 3c",
               PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA);
    end
    tick();
    n_checks++;
    if ({PSEL1, PSEL2, PENABLE, req_ready} !== {1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_access: got sel1=%b sel2=%b en=%b rdy=%b exp 1 0 1 0", PSEL1, PSEL2, PENABLE, req_ready);
    end
    tick();
    n_checks++;
    if ({rsp_valid, PSEL1, PENABLE, req_ready, PADDR, PWRITE} !== {1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_done: got v=%b sel1=%b en=%b rdy=%b a=%h wr=%b exp 1 0 0 1 a5 1",
               rsp_valid, PSEL1, PENABLE, req_ready, PADDR, PWRITE);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_pulse_width: got rsp_valid=%b exp 0", rsp_valid);
    end
  endtask

  task automatic test_read_slave2();
    PREADY1 = 1'b0; PRDATA1 = 8'h11; PREADY2 = 1'b1; PRDATA2 = 8'h77;
    start_req(1'b0, 9'h105, 8'h00);
    push_exp(8'h77, 1'b0);
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE, PADDR} !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h05}) begin
      n_fail++;
      $display("FAIL rd2_setup: got sel1=%b sel2=%b en=%b wr=%b a=%h exp 0 1 0 0 05",
               PSEL1, PSEL2, PENABLE, PWRITE, PADDR);
    end
    tick();
    tick();
    n_checks++;
    if ({rsp_valid, PSEL2} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rd2_done: got v=%b sel2=%b exp 1 0", rsp_valid, PSEL2);
    end
    tick();
  endtask

  task automatic test_wait_states();
    int cnt0;
    PREADY1 = 1'b0; PRDATA1 = 8'h5A; PREADY2 = 1'b1; PRDATA2 = 8'h99;
    start_req(1'b0, 9'h033, 8'h00);
    push_exp(8'h5A, 1'b0);
    cnt0 = rsp_cnt;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({PSEL1, PSEL2, PENABLE, PADDR, rsp_valid} !== {1'b1, 1'b0, 1'b1, 8'h33, 1'b0}) begin
        n_fail++;
        $display("FAIL wait_access_%0d: got sel1=%b sel2=%b en=%b a=%h v=%b exp 1 0 1 33 0",
                 i, PSEL1, PSEL2, PENABLE, PADDR, rsp_valid);
      end
      if (i == 3) PREADY1 = 1'b1;
    end
    tick();
    n_checks++;
    if ({rsp_valid, PSEL1, PENABLE} !== {1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL wait_done: got v=%b sel1=%b en=%b exp 1 0 0", rsp_valid, PSEL1, PENABLE);
    end
    tick();
    tick();
    n_checks++;
    if (rsp_cnt - cnt0 !== 1) begin
      n_fail++;
      $display("FAIL wait_single_rsp: got %0d responses exp 1", rsp_cnt - cnt0);
    end
    PREADY2 = 1'b0;
  endtask

  task automatic test_timeout(input logic ready_at_limit);
    PREADY1 = 1'b0; PRDATA1 = 8'hC7;
    start_req(1'b0, 9'h0C3, 8'h00);
    if (ready_at_limit) push_exp(8'hC7, 1'b0);
    else                push_exp(8'h00, 1'b1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if ({PSEL1, PENABLE, rsp_valid} !== {1'b1, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL tmo_access_%0d_%0d: got sel1=%b en=%b v=%b exp 1 1 0",
                 ready_at_limit, i, PSEL1, PENABLE, rsp_valid);
      end
    end
    if (ready_at_limit) PREADY1 = 1'b1;
    tick();
    n_checks++;
    if ({rsp_valid, rsp_err, PSEL1, PENABLE, req_ready} !== {1'b1, ~ready_at_limit, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL tmo_end_%0d: got v=%b err=%b sel1=%b en=%b rdy=%b exp 1 %b 0 0 1",
               ready_at_limit, rsp_valid, rsp_err, PSEL1, PENABLE, req_ready, ~ready_at_limit);
    end
    PREADY1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int cnt0;
    PREADY1 = 1'b0;
    cnt0 = rsp_cnt;
    start_req(1'b1, 9'h044, 8'h12);
    tick();
    req_valid = 1'b0;
    tick();
    #2;
    PRESETn = 1'b0;
    #1;
    n_checks++;
    if ({PSEL1, PENABLE, req_ready} !== {1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_async: got sel1=%b en=%b rdy=%b exp 0 0 0", PSEL1, PENABLE, req_ready);
    end
    tick();
    PRESETn = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, PADDR, rsp_valid} !== {1'b1, 8'h00, 1'b0} || rsp_cnt != cnt0) begin
      n_fail++;
      $display("FAIL rst_mid_release: got rdy=%b a=%h v=%b rsps=%0d exp 1 00 0 0",
               req_ready, PADDR, rsp_valid, rsp_cnt - cnt0);
    end
    PREADY2 = 1'b1;
    start_req(1'b1, 9'h1AA, 8'h55);
    push_exp(8'h00, 1'b0);
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({PSEL2, PENABLE, PADDR, PWDATA} !== {1'b1, 1'b0, 8'hAA, 8'h55}) begin
      n_fail++;
      $display("FAIL rst_first_accept: got sel2=%b en=%b a=%h d=%h exp 1 0 aa 55", PSEL2, PENABLE, PADDR, PWDATA);
    end
    tick();
    tick();
    tick();
    PREADY2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, d;
    PREADY1 = 1'b1; PRDATA1 = 8'hEE; PREADY2 = 1'b0;
    start_req(1'b1, 9'h010, 8'hC0);
    push_exp(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      a = 8'h10 + 8'(i);
      d = 8'hC0 + 8'(i);
      tick();
      PREADY2 = ~PREADY2;
      n_checks++;
      if ({PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, 1'b0, 1'b1, a, d}) begin
        n_fail++;
        $display("FAIL b2b_setup_%0d: got sel1=%b sel2=%b en=%b wr=%b a=%h d=%h exp 1 0 0 1 %h %h",
                 i, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, a, d);
      end
      if (i < 2) begin
        start_req(1'b1, {1'b0, a + 8'd1}, d + 8'd1);
        push_exp(8'h00, 1'b0);
      end else begin
        req_valid = 1'b0;
      end
      tick();
      PREADY2 = ~PREADY2;
      n_checks++;
      if ({PSEL1, PENABLE, PADDR, PWDATA, req_ready} !== {1'b1, 1'b1, a, d, 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_access_%0d: got sel1=%b en=%b a=%h d=%h rdy=%b exp 1 1 %h %h 0",
                 i, PSEL1, PENABLE, PADDR, PWDATA, req_ready, a, d);
      end
      tick();
      PREADY2 = ~PREADY2;
      n_checks++;
      if ({rsp_valid, req_ready, PSEL1, PENABLE} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_done_%0d: got v=%b rdy=%b sel1=%b en=%b exp 1 1 0 0",
                 i, rsp_valid, req_ready, PSEL1, PENABLE);
      end
    end
    tick();
    n_checks++;
    if ({rsp_valid, PSEL1, PSEL2} !== {1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_idle: got v=%b sel1=%b sel2=%b exp 0 0 0", rsp_valid, PSEL1, PSEL2);
    end
  endtask

  initial begin
    test_reset();
    test_write_slave1();
    test_read_slave2();
    test_wait_states();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    test_back_to_back();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending responses exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: max ACCESS cycles with PREADY low before the transfer is aborted (legal range 2..255).
REQ-002 PCLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 PRESETn  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  requester has a transfer pending.
REQ-005 req_write  in  1  1 = write, 0 = read.
REQ-006 req_addr  in  9  bit 8 selects the slave (0 = slave1, 1 = slave2); bits 7:0 form the slave address.
REQ-007 req_wdata  in  8  write data.
REQ-008 req_ready  out  1  controller can accept a request this cycle.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_rdata  out  8  read data; valid with rsp_valid.
REQ-011 rsp_err  out  1  timeout abort; valid with rsp_valid.
REQ-012 PSEL1, PSEL2  out  1 each  slave selects.
REQ-013 PENABLE, PWRITE  out  1 each  APB enable and direction.
REQ-014 PADDR, PWDATA  out  8 each  APB address and write data.
REQ-015 PREADY1, PREADY2  in  1 each  slave ready signals.
REQ-016 PRDATA1, PRDATA2  in  8 each  slave read data.

Function
REQ-017 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-018 req_ready SHALL equal 1 exactly when the state is IDLE and PRESETn is high.
REQ-019 On req_valid && req_ready, the controller SHALL register write, addr and wdata and move to SETUP on the next edge.
REQ-020 In SETUP, the selected PSELx SHALL be 1 and PENABLE SHALL be 0; the next state SHALL be ACCESS unconditionally.
REQ-021 In ACCESS, the selected PSELx and PENABLE SHALL both be 1.
REQ-022 The controller SHALL remain in ACCESS while the selected PREADY is 0.
REQ-023 PREADY from the non-selected slave SHALL be ignored.
REQ-024 PADDR, PWDATA and PWRITE SHALL be registered from the captured request and held stable through SETUP and ACCESS.
REQ-025 In IDLE, PSEL1, PSEL2 and PENABLE SHALL be 0, and PADDR, PWDATA and PWRITE SHALL hold their last values.
REQ-026 PSEL1 and PSEL2 SHALL never both be 1.
REQ-027 When the selected PREADY is 1 in ACCESS: the FSM SHALL go to IDLE; rsp_valid SHALL be 1 for exactly the following cycle with rsp_err = 0; for a read, rsp_rdata SHALL be the selected PRDATA sampled at that edge.
REQ-028 For a write completion, rsp_rdata SHALL be 0.
REQ-029 An 8-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle in which PREADY is low.
REQ-030 When the wait counter reaches TIMEOUT-1 with PREADY still low: the FSM SHALL go to IDLE; rsp_valid SHALL be 1 for one cycle with rsp_err = 1 and rsp_rdata = 0.
REQ-031 If PREADY is 1 in the same cycle the timeout would fire, the transfer SHALL complete normally (rsp_err = 0).
REQ-032 The minimum transfer SHALL take 3 cycles (IDLE accept, SETUP, ACCESS); the next request SHALL be accepted in the cycle rsp_valid is high.
REQ-033 req_valid while req_ready = 0 SHALL be ignored; the requester holds the request until it is accepted.

Reset
REQ-034 While PRESETn = 0, regardless of PCLK: state = IDLE; PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the wait counter SHALL all be 0.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer with no rsp_valid, and SHALL drop PSELx and PENABLE immediately.
REQ-036 After PRESETn deasserts, the first request SHALL be accepted on the first edge with req_valid = 1.

Verification
REQ-037 Write 0x0A5 data 0x3C, PREADY1 high in ACCESS -> PSEL1 high for 2 cycles with PENABLE 0 then 1, PADDR = 0xA5, PWRITE = 1; rsp_valid 1 cycle with rsp_err = 0; PSEL2 stays 0.
REQ-038 Read 0x105, PREADY2 high, PRDATA2 = 0x77 -> PSEL2 asserted, PADDR = 0x05; rsp_rdata = 0x77 with rsp_valid.
REQ-039 Read on slave1 with PREADY1 low for 3 ACCESS cycles, then high -> ACCESS lasts 4 cycles with PADDR, PSEL1 and PENABLE stable throughout; single rsp_valid.
REQ-040 TIMEOUT = 16, PREADY1 held low -> after 16 ACCESS cycles the FSM returns to IDLE; rsp_valid = 1 with rsp_err = 1 and rsp_rdata = 0.
REQ-041 PRESETn pulsed low during ACCESS -> PSEL1 and PENABLE go low asynchronously, no rsp_valid, req_ready = 1 after release.
REQ-042 Back-to-back writes with req_valid held high -> second accept in the rsp_valid cycle; 3-cycle period; PREADY2 toggling while slave1 is selected has no effect.
